// File: rtl/seq_pattern_gen_if.sv
// Request handshake and serial-stream bundle between a pattern source and seq_pattern_gen.
interface seq_pattern_gen_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_sel;
  logic             req_ready;
  logic             sdata;
  logic             last;
  logic             busy;
  logic [CNT_W-1:0] pat_cnt;

  modport master (
    output req_valid, req_sel,
    input  req_ready, sdata, last, busy, pat_cnt
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, sdata, last, busy, pat_cnt
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial "110"/"11110" pattern transmitter: accepts one request at a time, shifts the
// pattern out MSB first with a last marker, then forces a zero gap before accepting again.
module seq_pattern_gen #(
  parameter int GAP_BITS = 2,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [4:0] PAT_SHORT = 5'b11000;
  localparam logic [4:0] PAT_LONG  = 5'b11110;
  localparam bit         HAS_GAP   = (GAP_BITS > 0);
  localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(GAP_BITS - 1) : 4'd0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_shift;
  logic [4:0]       w_shift_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_pat_cnt;
  logic [CNT_W-1:0] w_pat_cnt_nxt;
  logic             r_sdata;
  logic             r_last;
  logic             r_busy;
  logic             w_ready;
  logic             w_accept;

  assign w_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept = w_ready && bus.req_valid;

  // r_cnt counts remaining pattern bits in SHIFT and remaining zero bits in GAP
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_pat_cnt_nxt = r_pat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_shift_nxt = bus.req_sel ? PAT_LONG : PAT_SHORT;
          w_cnt_nxt   = bus.req_sel ? 4'd4 : 4'd2;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == 4'd0) begin
          w_pat_cnt_nxt = r_pat_cnt + CNT_W'(1);
          w_shift_nxt   = 5'd0;
          w_cnt_nxt     = GAP_LOAD;
          w_state_nxt   = HAS_GAP ? ST_GAP : ST_IDLE;
        end else begin
          w_shift_nxt = {r_shift[3:0], 1'b0};
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_shift_nxt = 5'd0;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so the first bit follows the handshake edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= 5'd0;
      r_cnt     <= 4'd0;
      r_pat_cnt <= '0;
      r_sdata   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pat_cnt <= w_pat_cnt_nxt;
      r_sdata   <= (w_state_nxt == ST_SHIFT) && w_shift_nxt[4];
      r_last    <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == 4'd0);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.sdata     = r_sdata;
  assign bus.last      = r_last;
  assign bus.busy      = r_busy;
  assign bus.pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench: default instance plus a GAP_BITS=0/CNT_W=2 instance, both checked every
// cycle against a queue-of-upcoming-bits reference model, plus directed table and corner sequences.
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.CNT_W(8)) bus_a ();
  seq_pattern_gen_if #(.CNT_W(2)) bus_b ();

  seq_pattern_gen #(.GAP_BITS(2), .CNT_W(8)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_pattern_gen #(.GAP_BITS(0), .CNT_W(2)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  // Reference model: per instance, the list of bits still to appear on the line
  bit m_bit  [0:1][0:15];
  bit m_last [0:1][0:15];
  int m_len  [0:1];
  int m_cnt  [0:1];
  int m_gap  [0:1];
  int m_mod  [0:1];
  bit m_known = 1'b0;
  logic [1:0] det_hist = 2'b00;

  // Values of instance A (and B's counter) sampled in the most recent cycle
  logic s_sd, s_ls, s_bz, s_rd;
  logic [7:0] s_cnt;
  logic [1:0] s_cnt_b;

  typedef struct {
    logic r, v, sel;
    bit   chk;
    logic sd, ls, bz, rd;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl [0:16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_check(input int d, input logic sd, input logic ls, input logic bz,
                             input logic rd, input logic [31:0] cnt);
    bit has;
    has = (m_len[d] > 0);
    check($sformatf("dut%0d sdata", d), {31'd0, sd}, {31'd0, has ? m_bit[d][0] : 1'b0});
    check($sformatf("dut%0d last", d), {31'd0, ls}, {31'd0, has ? m_last[d][0] : 1'b0});
    check($sformatf("dut%0d busy", d), {31'd0, bz}, {31'd0, has});
    check($sformatf("dut%0d req_ready", d), {31'd0, rd}, {31'd0, !has && !rst});
    check($sformatf("dut%0d pat_cnt", d), cnt, m_cnt[d]);
  endtask

  task automatic model_step(input int d, input logic r, input logic v, input logic sel);
    int plen;
    if (r) begin
      m_len[d] = 0;
      m_cnt[d] = 0;
    end else if (m_len[d] > 0) begin
      if (m_last[d][0]) m_cnt[d] = (m_cnt[d] + 1) % m_mod[d];
      for (int i = 0; i < 15; i++) begin
        m_bit[d][i]  = m_bit[d][i+1];
        m_last[d][i] = m_last[d][i+1];
      end
      m_bit[d][15]  = 1'b0;
      m_last[d][15] = 1'b0;
      m_len[d]--;
    end else if (v) begin
      plen = sel ? 5 : 3;
      for (int i = 0; i < 16; i++) begin
        m_bit[d][i]  = (i < plen - 1);
        m_last[d][i] = (i == plen - 1);
      end
      m_len[d] = plen + m_gap[d];
    end
  endtask

  // One clock: drive inputs, sample/check at the falling edge, advance the model at the rising edge
  task automatic cycle(input logic r, input logic v, input logic sel);
    rst = r;
    bus_a.req_valid = v;  bus_a.req_sel = sel;
    bus_b.req_valid = v;  bus_b.req_sel = sel;
    @(negedge clk);
    s_sd = bus_a.sdata;  s_ls = bus_a.last;  s_bz = bus_a.busy;
    s_rd = bus_a.req_ready;  s_cnt = bus_a.pat_cnt;  s_cnt_b = bus_b.pat_cnt;
    if (m_known) begin
      model_check(0, bus_a.sdata, bus_a.last, bus_a.busy, bus_a.req_ready, {24'd0, bus_a.pat_cnt});
      model_check(1, bus_b.sdata, bus_b.last, bus_b.busy, bus_b.req_ready, {30'd0, bus_b.pat_cnt});
      check("detector y vs last", {31'd0, bus_a.last},
            {31'd0, (bus_a.sdata == 1'b0) && (det_hist == 2'b11)});
    end
    det_hist = r ? 2'b00 : {det_hist[0], bus_a.sdata};
    model_step(0, r, v, sel);
    model_step(1, r, v, sel);
    if (r) m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int n_last;
    int seen;
    logic [2:0] bits;
    logic [1:0] prev_b;
    logic [1:0] cnt_seq [0:4];
    logic sels [0:2];

    m_gap[0] = 2;  m_mod[0] = 256;
    m_gap[1] = 0;  m_mod[1] = 4;
    for (int d = 0; d < 2; d++) begin
      m_len[d] = 0;
      m_cnt[d] = 0;
    end

    //           r     v     sel   chk   sd    ls    bz    rd    cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};

    // Directed: reset, short pattern with gap, long pattern with a stray pulse mid-shift
    for (int i = 0; i <= 16; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].sel);
      if (tbl[i].chk) begin
        check($sformatf("tbl[%0d] sdata", i), {31'd0, s_sd}, {31'd0, tbl[i].sd});
        check($sformatf("tbl[%0d] last", i), {31'd0, s_ls}, {31'd0, tbl[i].ls});
        check($sformatf("tbl[%0d] busy", i), {31'd0, s_bz}, {31'd0, tbl[i].bz});
        check($sformatf("tbl[%0d] req_ready", i), {31'd0, s_rd}, {31'd0, tbl[i].rd});
        check($sformatf("tbl[%0d] pat_cnt", i), {24'd0, s_cnt}, {24'd0, tbl[i].cnt});
      end
    end

    // Back-to-back: valid held, select 0,1,0 advancing after each acceptance
    sels[0] = 1'b0;  sels[1] = 1'b1;  sels[2] = 1'b0;
    idx = 0;
    n_last = 0;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      cycle(1'b0, 1'b1, sels[idx]);
      if (s_ls) n_last++;
      if (s_rd) idx++;
    end
    check("b2b accepted", idx, 3);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (s_ls) n_last++;
    end
    check("b2b last pulses", n_last, 3);
    check("b2b pat_cnt", {24'd0, s_cnt}, 32'd5);

    // Reset during the third bit of a long pattern, then a clean short pattern
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("abort 3rd bit", {31'd0, s_sd}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    check("abort sdata", {31'd0, s_sd}, 32'd0);
    check("abort last", {31'd0, s_ls}, 32'd0);
    check("abort busy", {31'd0, s_bz}, 32'd0);
    check("abort ready", {31'd0, s_rd}, 32'd0);
    check("abort pat_cnt", {24'd0, s_cnt}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    check("post-reset accept", {31'd0, s_rd}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      bits[2-k] = s_sd;
    end
    check("post-reset 110", {29'd0, bits}, 32'd6);
    check("post-reset last", {31'd0, s_ls}, 32'd1);

    // Zero-gap instance: five held short requests, counter wraps through 0
    cnt_seq[0] = 2'd1;  cnt_seq[1] = 2'd2;  cnt_seq[2] = 2'd3;
    cnt_seq[3] = 2'd0;  cnt_seq[4] = 2'd1;
    cycle(1'b1, 1'b0, 1'b0);
    prev_b = 2'd0;
    seen = 0;
    for (int c = 0; c < 26; c++) begin
      cycle(1'b0, (c < 20) ? 1'b1 : 1'b0, 1'b0);
      if (s_cnt_b != prev_b) begin
        if (seen < 5) check($sformatf("wrap seq[%0d]", seen), {30'd0, s_cnt_b}, {30'd0, cnt_seq[seen]});
        seen++;
        prev_b = s_cnt_b;
      end
    end
    check("wrap seq length", seen, 5);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
